// File: rtl/modular_adder.sv
// Registered modular adder: (a + b) mod m with one cycle of latency.
// Modulus is a run-time input; range violations raise an error flag.
module modular_adder #(
  parameter int BITWIDTH = 32
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData0,
  input  logic [BITWIDTH-1:0] iData1,
  input  logic [BITWIDTH-1:0] iMod,
  output logic [BITWIDTH-1:0] oData,
  output logic                oValid,
  output logic                oErr
);

  logic [BITWIDTH:0]   sum;
  logic [BITWIDTH:0]   mod_ext;
  logic [BITWIDTH:0]   diff;
  logic                sum_ge;
  logic                mod_zero;
  logic                a_bad;
  logic                b_bad;
  logic                err;
  logic [BITWIDTH-1:0] result;

  assign mod_ext = {1'b0, iMod};

  // Sum at full width so the carry is kept, then one conditional subtract.
  // The compare is done directly on sum rather than on the borrow of diff,
  // because out-of-range operands can push sum past 2*iMod.
  always_comb begin
    sum      = {1'b0, iData0} + {1'b0, iData1};
    diff     = sum - mod_ext;
    sum_ge   = (sum >= mod_ext);
    mod_zero = (iMod == '0);
    a_bad    = (iData0 >= iMod);
    b_bad    = (iData1 >= iMod);
    err      = mod_zero | a_bad | b_bad;
    result   = '0;
    if (mod_zero)
      result = '0;
    else if (sum_ge)
      result = diff[BITWIDTH-1:0];
    else
      result = sum[BITWIDTH-1:0];
  end

  // Output registers: reset, then clear, then capture; idle holds data.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oData  <= '0;
      oValid <= 1'b0;
      oErr   <= 1'b0;
    end else if (iClr) begin
      oData  <= '0;
      oValid <= 1'b0;
      oErr   <= 1'b0;
    end else if (iEn) begin
      oData  <= result;
      oValid <= 1'b1;
      oErr   <= err;
    end else begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modular_adder.sv
// Directed bench for modular_adder.
// Expected values are hand-computed or from a small model.
module tb_modular_adder;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] m;
  logic [31:0] data;
  logic        valid;
  logic        err;

  int total;
  int bad;

  modular_adder #(.BITWIDTH(32)) dut (
    .iClk  (clk),
    .iRst  (rst),
    .iEn   (en),
    .iClr  (clr),
    .iData0(a),
    .iData1(b),
    .iMod  (m),
    .oData (data),
    .oValid(valid),
    .oErr  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag,
                      input logic [31:0] d,
                      input logic v,
                      input logic e);
    chk({tag, ".data"}, data, d);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
  endtask

  task automatic step(input logic [31:0] ia,
                      input logic [31:0] ib,
                      input logic [31:0] im,
                      input logic ien,
                      input logic iclr);
    a   = ia;
    b   = ib;
    m   = im;
    en  = ien;
    clr = iclr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] exp_d;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b1;
    clr   = 1'b0;
    a     = $urandom;
    b     = $urandom;
    m     = $urandom;
    #1;
    outs("reset_async", 32'd0, 1'b0, 1'b0);
    step($urandom, $urandom, $urandom, 1'b1, 1'b0);
    outs("reset_held", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(32'd5, 32'd7, 32'd23, 1'b0, 1'b0);
    outs("reset_release", 32'd0, 1'b0, 1'b0);

    step(32'd5, 32'd7, 32'd23, 1'b1, 1'b0);
    outs("no_wrap", 32'd12, 1'b1, 1'b0);
    step(32'd1, 32'd1, 32'd23, 1'b0, 1'b0);
    outs("hold", 32'd12, 1'b0, 1'b0);
    step(32'd22, 32'd22, 32'd23, 1'b1, 1'b0);
    outs("wrap_max", 32'd21, 1'b1, 1'b0);
    step(32'd11, 32'd12, 32'd23, 1'b1, 1'b0);
    outs("wrap_zero", 32'd0, 1'b1, 1'b0);
    step(32'd0, 32'd0, 32'd23, 1'b1, 1'b0);
    outs("zeros", 32'd0, 1'b1, 1'b0);
    step(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0);
    outs("full_width", 32'hFFFF_FFFD, 1'b1, 1'b0);
    step(32'd3, 32'd4, 32'd23, 1'b1, 1'b1);
    outs("clr_with_en", 32'd0, 1'b0, 1'b0);
    step(32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
    outs("mod_zero", 32'd0, 1'b1, 1'b1);
    step(32'd30, 32'd1, 32'd23, 1'b1, 1'b0);
    outs("a_range", 32'd8, 1'b1, 1'b1);
    step(32'd2, 32'd23, 32'd23, 1'b1, 1'b0);
    outs("b_range", 32'd2, 1'b1, 1'b1);

    step(32'd9, 32'd9, 32'd23, 1'b1, 1'b0);
    outs("pre_rst", 32'd18, 1'b1, 1'b0);
    a = 32'd1;
    #2;
    rst = 1'b1;
    #1;
    outs("mid_rst", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      ra    = 32'($urandom_range(22, 0));
      rb    = 32'($urandom_range(22, 0));
      exp_d = (ra + rb) % 32'd23;
      step(ra, rb, 32'd23, 1'b1, 1'b0);
      outs("random", exp_d, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
